// File: rtl/sha256_w_stream_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sha256_w_stream_gen
// Description : Streams the SHA-256 message schedule W0..W(ROUNDS-1) for one
//               512-bit block using a 16-word sliding window.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_w_stream_gen #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_index,
    output logic         w_last,
    output logic         busy
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_emit  = 1'b1;
    localparam logic [5:0] c_last_idx = 6'(ROUNDS - 1);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [31:0] r_win [16];
    logic [5:0]  r_t;
    logic        w_accept;
    logic        w_advance;
    logic        w_at_last;
    logic [31:0] w_new;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign w_at_last = (r_t == c_last_idx);
    assign w_accept  = in_valid && in_ready;
    assign w_advance = w_valid && w_ready && !w_at_last;
    assign w_new     = sigma1(r_win[14]) + r_win[9] + sigma0(r_win[1]) + r_win[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_state_nxt = c_st_emit;
            c_st_emit: if (w_ready && w_at_last) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Outputs; in_ready is masked by rst so no block can slip in on a reset edge
    always_comb begin
        in_ready = 1'b0;
        w_valid  = 1'b0;
        busy     = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            c_st_idle: in_ready = !rst;
            c_st_emit: begin
                w_valid = 1'b1;
                busy    = 1'b1;
                w_last  = w_at_last;
            end
            default: ;
        endcase
        w_out   = r_win[0];
        w_index = r_t;
    end

    // Schedule window: load on accept, shift in the new word on each handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_win[i] <= 32'h0;
            r_t <= 6'd0;
        end else if (w_accept) begin
            for (int i = 0; i < 16; i++) r_win[i] <= block_in[511 - 32*i -: 32];
            r_t <= 6'd0;
        end else if (w_advance) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_new;
            r_t       <= r_t + 6'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_w_stream_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sha256_w_stream_gen
// Description : Scoreboard bench for sha256_w_stream_gen (ROUNDS=64 and 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_w_stream_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, w_valid, w_ready, w_last, busy;
    logic [511:0] block_in;
    logic [31:0]  w_out;
    logic [5:0]   w_index;

    logic         in_valid16, in_ready16, w_valid16, w_ready16, w_last16, busy16;
    logic [511:0] block_in16;
    logic [31:0]  w_out16;
    logic [5:0]   w_index16;

    sha256_w_stream_gen #(.ROUNDS(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .block_in(block_in), .w_valid(w_valid), .w_ready(w_ready),
        .w_out(w_out), .w_index(w_index), .w_last(w_last), .busy(busy)
    );

    sha256_w_stream_gen #(.ROUNDS(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .block_in(block_in16), .w_valid(w_valid16), .w_ready(w_ready16),
        .w_out(w_out16), .w_index(w_index16), .w_last(w_last16), .busy(busy16)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] w;
        logic [5:0]  idx;
        logic        last;
    } exp_t;
    exp_t exp_q[$];

    logic [511:0] c_abc;
    logic [511:0] c_zero;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Reference schedule computed from the textbook recurrence over a full array
    task automatic model(input logic [511:0] blk, output logic [31:0] w [64]);
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    endtask

    task automatic push_block(input logic [511:0] blk, input int rounds);
        logic [31:0] w [64];
        exp_t e;
        model(blk, w);
        for (int t = 0; t < rounds; t++) begin
            e.w    = w[t];
            e.idx  = 6'(t);
            e.last = (t == rounds - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a block and returns one cycle after the accepting edge
    task automatic send(input logic [511:0] blk, input bit keep_valid);
        int n = 0;
        in_valid = 1'b1;
        block_in = blk;
        #1;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        step();
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // Consumes n words against the scoreboard; every valid cycle (stalled or not)
    // is compared to the queue head
    task automatic drain(input int n, input bit throttle, output int cycles);
        int popped = 0;
        exp_t e;
        cycles = 0;
        while (popped < n && cycles < 2000) begin
            w_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (w_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(w_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("w_out",   w_out,          e.w);
                    chk("w_index", 32'(w_index),   32'(e.idx));
                    chk("w_last",  32'(w_last),    32'(e.last));
                    chk("busy",    32'(busy),      32'd1);
                    chk("in_ready_emit", 32'(in_ready), 32'd0);
                    if (w_ready) begin
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end
            step();
            cycles++;
        end
        if (popped < n) chk("drain_timeout", 32'(popped), 32'(n));
        w_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [31:0] w16 [64];

        c_abc  = {32'h61626380, {14{32'h0}}, 32'h00000018};
        c_zero = '0;
        rst = 1'b1; in_valid = 1'b0; w_ready = 1'b0; block_in = '0;
        in_valid16 = 1'b0; w_ready16 = 1'b0; block_in16 = '0;

        // Reset state
        repeat (3) step();
        chk("rst_w_valid",  32'(w_valid),  32'd0);
        chk("rst_w_out",    w_out,         32'd0);
        chk("rst_w_index",  32'(w_index),  32'd0);
        chk("rst_w_last",   32'(w_last),   32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_in_ready16", 32'(in_ready16), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // "abc" block at full rate; anchor known words of the schedule
        push_block(c_abc, 64);
        chk("abc_w16_model", exp_q[16].w, 32'h61626380);
        chk("abc_w17_model", exp_q[17].w, 32'h000F0000);
        chk("abc_w18_model", exp_q[18].w, 32'h7DA86405);
        send(c_abc, 1'b0);
        chk("abc_first_latency", 32'(w_valid), 32'd1);
        drain(64, 1'b0, cyc);
        chk("abc_cycles", 32'(cyc), 32'd64);
        chk("abc_in_ready_65", 32'(in_ready), 32'd1);
        chk("abc_idle_valid",  32'(w_valid),  32'd0);
        chk("abc_idle_last",   32'(w_last),   32'd0);
        chk("abc_idle_busy",   32'(busy),     32'd0);

        // All-zero block
        push_block(c_zero, 64);
        send(c_zero, 1'b0);
        drain(64, 1'b0, cyc);
        chk("zero_idle_valid", 32'(w_valid), 32'd0);

        // "abc" block under random backpressure
        push_block(c_abc, 64);
        send(c_abc, 1'b0);
        drain(64, 1'b1, cyc);
        chk("thr_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("thr_idle_valid",  32'(w_valid), 32'd0);

        // Second block waiting on in_valid while the first is emitted
        push_block(c_abc, 64);
        send(c_abc, 1'b1);
        block_in = c_zero;
        drain(64, 1'b0, cyc);
        chk("b2b_gap_in_ready", 32'(in_ready), 32'd1);
        chk("b2b_gap_valid",    32'(w_valid),  32'd0);
        step();
        in_valid = 1'b0;
        chk("b2b_second_valid", 32'(w_valid),  32'd1);
        chk("b2b_second_index", 32'(w_index),  32'd0);
        chk("b2b_second_w0",    w_out,         32'd0);
        push_block(c_zero, 64);
        drain(64, 1'b0, cyc);
        chk("b2b_idle_valid", 32'(w_valid), 32'd0);

        // Reset while w_index == 20
        push_block(c_abc, 64);
        send(c_abc, 1'b0);
        drain(20, 1'b0, cyc);
        w_ready = 1'b0;
        #1;
        chk("abort_index_20", 32'(w_index), 32'd20);
        rst = 1'b1;
        #1;
        chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
        step();
        chk("abort_w_valid", 32'(w_valid), 32'd0);
        chk("abort_busy",    32'(busy),    32'd0);
        chk("abort_w_index", 32'(w_index), 32'd0);
        chk("abort_w_out",   w_out,        32'd0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready_rel", 32'(in_ready), 32'd1);
        exp_q.delete();
        push_block(c_zero, 64);
        send(c_zero, 1'b0);
        drain(64, 1'b0, cyc);
        w_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("abort_no_extra", 32'(w_valid), 32'd0);
            step();
        end
        w_ready = 1'b0;

        // ROUNDS=16 build
        model(c_abc, w16);
        in_valid16 = 1'b1;
        block_in16 = c_abc;
        step();
        in_valid16 = 1'b0;
        w_ready16  = 1'b1;
        for (int t = 0; t < 16; t++) begin
            chk("r16_valid", 32'(w_valid16), 32'd1);
            chk("r16_w_out", w_out16,        w16[t]);
            chk("r16_index", 32'(w_index16), 32'(t));
            chk("r16_last",  32'(w_last16),  32'(t == 15));
            step();
        end
        chk("r16_done_valid",    32'(w_valid16),  32'd0);
        chk("r16_done_in_ready", 32'(in_ready16), 32'd1);
        w_ready16 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha256_w_stream_gen.md
SHA256_W_STREAM_GEN -- requirements
Module: sha256_w_stream_gen

Interface
REQ-001 Parameter ROUNDS, default 64, number of schedule words W0..W(ROUNDS-1) emitted per block; legal range 16..64.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  block_in holds a valid 512-bit message block.
REQ-005 in_ready  output  1  block accepted on a cycle where in_valid and in_ready are both high.
REQ-006 block_in  input  512  message block, MSB-first: W0 = block_in[511:480] ... W15 = block_in[31:0].
REQ-007 w_valid  output  1  w_out holds a valid schedule word.
REQ-008 w_ready  input  1  downstream accepts the word on a cycle where w_valid and w_ready are both high.
REQ-009 w_out  output  32  current schedule word W(w_index).
REQ-010 w_index  output  6  round index t of w_out.
REQ-011 w_last  output  1  high with w_valid when w_index == ROUNDS-1.
REQ-012 busy  output  1  high from block acceptance until the last word is accepted.

Function
REQ-013 The block SHALL implement two states: IDLE and EMIT.
REQ-014 In IDLE: in_ready=1, w_valid=0, busy=0; on in_valid&in_ready, load the 16-word window from block_in, set t=0, and go to EMIT.
REQ-015 In EMIT: in_ready=0, w_valid=1, busy=1, w_out=window[0], w_index=t.
REQ-016 First word latency SHALL be one cycle: w_valid is high in the cycle after the accept edge.
REQ-017 On w_valid&w_ready with t<ROUNDS-1: shift the window down one word, append Wnew = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], and set t=t+1.
REQ-018 sigma0(x) SHALL be ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-019 sigma1(x) SHALL be ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-020 Additions SHALL be modulo 2^32 with carries discarded.
REQ-021 Words W0..W15 SHALL appear unmodified from block_in, in order.
REQ-022 With w_valid high and w_ready low, w_out, w_index and w_last SHALL hold stable (no skip, no duplication).
REQ-023 On w_valid&w_ready with t==ROUNDS-1: go to IDLE; w_valid=0 and in_ready=1 in the next cycle.
REQ-024 in_valid during EMIT SHALL be ignored, with block_in not sampled; the upstream must hold the block until in_ready.
REQ-025 Peak throughput SHALL be one block per ROUNDS+1 cycles with w_ready tied high.
REQ-026 w_index SHALL never exceed ROUNDS-1 and SHALL not wrap within a block.

Reset
REQ-027 While RST is high at a clock edge, the block SHALL enter IDLE with w_valid=0, w_out=0, w_index=0, w_last=0, busy=0, window cleared.
REQ-028 in_ready SHALL be 0 during any cycle in which RST is sampled high, and 1 from the first cycle after RST is released.
REQ-029 RST during EMIT SHALL abort the block; no further words of it are emitted, and a new block is accepted normally after reset.

Verification
REQ-030 "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W0..W15 as loaded, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; 64 words total; w_last only at t=63; in_ready returns 1 at cycle 65 after accept.
REQ-031 All-zero block -> 64 words all 0x00000000, with indices 0..63 contiguous.
REQ-032 Random w_ready throttling (about 50%) on the "abc" block -> word sequence identical to REQ-030, with outputs stable during every stall.
REQ-033 in_valid held high with a second block presented during EMIT -> second block accepted only in the cycle after the first block's W63 handshake; its W0 appears one cycle later.
REQ-034 RST asserted while w_index=20 -> next cycle w_valid=0, busy=0, in_ready=1 after release; a following all-zero block yields exactly 64 zero words.
REQ-035 ROUNDS=16 build with the "abc" block -> exactly W0..W15 emitted, with w_last at t=15.
